muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide engine that produces the 64-bit {HI,LO} result and write strobe consumed by the HI/LO register in the MEM stage. It accepts MULT/MULTU/DIV/DIVU from EX, raises a stall to the pipeline while computing, and issues a single-cycle write of the full 64-bit result. Division is radix-2 restoring over 32 cycles. Multiplication completes in one compute cycle.

## Interface
- WIDTH, 32: operand width; the result is 2*WIDTH. Only 32 is supported.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  issue request, sampled in IDLE only
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand: multiplicand or dividend
- b  in  32  rt operand: multiplier or divisor
- flush  in  1  cancels any in-flight operation; no write results
- stall  out  1  pipeline hold request (combinational)
- hilo_we  out  1  one-cycle write strobe toward HI/LO
- hilo_o  out  64  result: {HI, LO}

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & !flush: latch op, a, b.
  - op[1]=0 goes to MUL; op[1]=1 goes to DIV with counter=0.
- MUL (1 cycle):
  - Computes the signed or unsigned 32x32 product into the result register.
  - Goes to DONE.
- DIV (32 cycles):
  - Operands are converted to absolute values when signed.
  - Each cycle performs one restoring step: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - After counter=31, the signed fixup is applied and the state goes to DONE.
- DONE (1 cycle):
  - hilo_we = !flush; hilo_o holds the result.
  - Always goes to IDLE. A start seen in DONE is ignored; the pipeline re-presents it.
- Result placement:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Signed divide: the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero (b==0), signed or unsigned: HI = a, LO = 32'hFFFF_FFFF. No exception is raised and no fixup is applied.
- 32'h8000_0000 / 32'hFFFF_FFFF (signed): LO = 32'h8000_0000, HI = 0, which is the natural wrap.
- Flush in MUL or DIV: the state goes to IDLE next cycle, hilo_we is never asserted, and the result register is left unchanged.
- stall = (IDLE & start & !flush) | MUL | DIV. It is low in DONE, so the pipeline advances in the same cycle the write occurs.

## Timing
- Reset: state=IDLE, stall=0, hilo_we=0, hilo_o=64'h0, counter=0.
- start accepted at cycle T:
  - Multiply: stall is high T..T+1; hilo_we is high at T+2 only.
  - Divide: stall is high T..T+32; hilo_we is high at T+33 only.
- hilo_o is valid from the DONE cycle and holds until the next operation completes.
- Back-to-back operations: the next start can be accepted at the earliest in the cycle after DONE.
- rst takes priority over everything, including mid-operation. The next cycle is IDLE with outputs at reset values.
- flush and start in the same IDLE cycle: start is ignored and stall stays 0.

## Structure
- Opcode encodings (MULT/MULTU/DIV/DIVU 2-bit codes) and FSM state encodings go in defines.vh, next to the existing EXE_* funct constants.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: 33-bit partial remainder, divisor, incoming dividend bit.
  - Outputs: next remainder and quotient bit.
- The FSM, counter, sign handling and the multiply all live in muldiv_unit.

## Test plan
- MULT a=-3 (FFFFFFFD), b=5 -> at T+2: hilo_we=1, hilo_o={FFFFFFFF, FFFFFFF1}; stall high for exactly 2 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> at T+2: hilo_o={FFFFFFFE, 00000001}.
- DIV a=-7, b=2 -> at T+33: LO=FFFFFFFD, HI=FFFFFFFF. DIVU a=100, b=7 -> LO=0000000E, HI=00000002. Stall high for 33 cycles.
- DIVU a=7, b=0 -> at T+33: HI=00000007, LO=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> LO=80000000, HI=0.
- DIV started at T, flush at T+10 -> stall=0 at T+11, no hilo_we, hilo_o unchanged. A new MULT at T+11 completes at T+13.
- rst asserted at T+5 of a DIV -> next cycle IDLE, stall=0, hilo_o=0, no hilo_we ever. Random signed/unsigned operand sweep checked against a reference model.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the multiply/divide engine.
// Provides operand width, opcode and FSM state encodings, the latched
// request payload, and small helpers for signedness and sign fixup.
package muldiv_unit_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  // MULT and DIV (op[0]=0) treat operands as two's complement.
  function automatic logic is_signed(input op_e op);
    return ~op[0];
  endfunction

  // Two's-complement negate when neg is set; used for abs() and sign fixup.
  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] x);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX/MEM-side handshake bundle for the multiply/divide engine.
// master: pipeline side (drives start/op/a/b/flush, sees stall and the result).
// slave:  muldiv_unit (drives stall, hilo_we, hilo_o).
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall;
  logic             hilo_we;
  logic [RES_W-1:0] hilo_o;

  modport master (
    output start, op, a, b, flush,
    input  stall, hilo_we, hilo_o
  );

  modport slave (
    input  start, op, a, b, flush,
    output stall, hilo_we, hilo_o
  );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step.
// rem      : current partial remainder (WIDTH+1 bits)
// divisor  : unsigned divisor
// dvd_bit  : next dividend bit shifted in
// rem_next : remainder after the trial subtract (restored if negative)
// q_bit    : quotient bit produced by this step
module muldiv_unit_div_step
  import muldiv_unit_pkg::*;
(
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned RW = WIDTH + 1;

  logic [SW-1:0] shifted;
  logic [SW-1:0] dvs_ext;

  // Shift in the dividend bit, keep the difference only if it is non-negative.
  always_comb begin
    shifted  = {rem, dvd_bit};
    dvs_ext  = {2'b00, divisor};
    q_bit    = (shifted >= dvs_ext);
    rem_next = q_bit ? RW'(shifted - dvs_ext) : RW'(shifted);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine feeding the HI/LO register.
// clk, rst : clock and synchronous active-high reset
// bus      : muldiv_unit_if.slave (start/op/a/b/flush in; stall/hilo_we/hilo_o out)
// Multiply takes one compute cycle; divide is 32 restoring steps. The full
// {HI,LO} result is written with a one-cycle hilo_we in DONE.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  state_e           state_q;
  req_t             req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [RES_W-1:0] result_q;

  logic             accept;
  logic             sgn_in;
  logic             sgn_q;
  logic [RES_W-1:0] mul_a;
  logic [RES_W-1:0] mul_b;
  logic [RES_W-1:0] product;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;
  logic             q_neg;
  logic             r_neg;
  logic [RES_W-1:0] div_res;

  assign accept = (state_q == ST_IDLE) & bus.start & ~bus.flush;
  assign sgn_in = is_signed(bus.op);
  assign sgn_q  = is_signed(req_q.op);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact.
  always_comb begin
    mul_a   = sgn_q ? {{WIDTH{req_q.a[WIDTH-1]}}, req_q.a} : {{WIDTH{1'b0}}, req_q.a};
    mul_b   = sgn_q ? {{WIDTH{req_q.b[WIDTH-1]}}, req_q.b} : {{WIDTH{1'b0}}, req_q.b};
    product = mul_a * mul_b;
  end

  muldiv_unit_div_step u_step (
    .rem      (rem_q),
    .divisor  (dvs_q),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // dvd_q shifts the dividend out of the top while quotient bits enter at the bottom.
  // Divide by zero bypasses the fixup and returns {a, all-ones}.
  always_comb begin
    q_raw   = {dvd_q[WIDTH-2:0], step_q};
    r_raw   = step_rem[WIDTH-1:0];
    q_neg   = sgn_q & (req_q.a[WIDTH-1] ^ req_q.b[WIDTH-1]);
    r_neg   = sgn_q & req_q.a[WIDTH-1];
    div_res = (req_q.b == '0) ? {req_q.a, {WIDTH{1'b1}}}
                              : {cond_neg(r_neg, r_raw), cond_neg(q_neg, q_raw)};
  end

  // Control FSM with counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_q   <= '{op: bus.op, a: bus.a, b: bus.b};
            dvd_q   <= cond_neg(sgn_in & bus.a[WIDTH-1], bus.a);
            dvs_q   <= cond_neg(sgn_in & bus.b[WIDTH-1], bus.b);
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= bus.op[1] ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
          end else begin
            result_q <= product;
            state_q  <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
          end else begin
            rem_q <= step_rem;
            dvd_q <= q_raw;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_q <= div_res;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // stall drops in DONE so the pipeline advances while the write happens.
  assign bus.stall   = accept | (state_q == ST_MUL) | (state_q == ST_DIV);
  assign bus.hilo_we = (state_q == ST_DONE) & ~bus.flush;
  assign bus.hilo_o  = result_q;

endmodule
